// File: rtl/maxpool_stream.sv
// Streaming KxK max-pool (K = 2 or 3, stride K) over a row-major signed
// pixel stream. Horizontal maxima are reduced on the fly; a row buffer
// indexed by window column folds the K rows of each window together.
module maxpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_COLS   = 256,
  parameter int ROW_W      = 16,
  localparam int COL_W     = $clog2(MAX_COLS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [COL_W-1:0]      cfg_cols,
  input  logic [ROW_W-1:0]      cfg_rows,
  input  logic                  cfg_pool,
  input  logic                  cfg_relu,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int BUF_D = (MAX_COLS / 2 > 0) ? MAX_COLS / 2 : 1;
  localparam int IDX_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int CW1   = COL_W + 1;
  localparam int RW1   = ROW_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state_q, state_d;

  // latched frame configuration
  logic [COL_W-1:0] cols_q, cols_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic             k3_q, k3_d;
  logic             relu_q, relu_d;

  // position counters
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       hpos_q, hpos_d;
  logic [1:0]       vpos_q, vpos_d;
  logic [IDX_W-1:0] wc_q, wc_d;

  // output register control
  logic m_valid_q, m_valid_d;
  logic m_last_q, m_last_d;

  // datapath storage (no reset)
  logic signed [DATA_WIDTH-1:0] hmax_q;
  logic signed [DATA_WIDTH-1:0] m_data_q;
  logic signed [DATA_WIDTH-1:0] rowbuf_q [BUF_D];

  logic signed [DATA_WIDTH-1:0] pix, hcur, bufrd, comb;
  logic [1:0]     kv, km1;
  logic           s_hs, m_hs, hdone, vdone, row_end, last_px, emit, last_win;
  logic [CW1-1:0] col_plus_k;
  logic [RW1-1:0] row_plus_k;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] relu(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic                         en
  );
    return (en && x < 0) ? '0 : x;
  endfunction

  assign s_ready = (state_q == RUN) && !(m_valid_q && !m_ready);
  assign s_hs    = s_valid && s_ready;
  assign m_hs    = m_valid_q && m_ready;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

  // window geometry and the horizontal/vertical reduction path
  always_comb begin
    kv         = k3_q ? 2'd3 : 2'd2;
    km1        = k3_q ? 2'd2 : 2'd1;
    pix        = s_data;
    hdone      = (hpos_q == km1);
    vdone      = (vpos_q == km1);
    row_end    = ((col_q + COL_W'(1)) == cols_q);
    last_px    = row_end && ((row_q + ROW_W'(1)) == rows_q);
    col_plus_k = {1'b0, col_q} + CW1'(kv);
    row_plus_k = {1'b0, row_q} + RW1'(kv);
    // no further complete window fits to the right / below this one
    last_win   = (col_plus_k >= {1'b0, cols_q}) && (row_plus_k >= {1'b0, rows_q});
    hcur       = (hpos_q == 2'd0) ? pix : smax(hmax_q, pix);
    bufrd      = rowbuf_q[wc_q];
    comb       = (vpos_q == 2'd0) ? hcur : smax(bufrd, hcur);
    emit       = s_hs && hdone && vdone;
  end

  // next-state for configuration, counters and output-register control
  always_comb begin
    cols_d    = cols_q;
    rows_d    = rows_q;
    k3_d      = k3_q;
    relu_d    = relu_q;
    col_d     = col_q;
    row_d     = row_q;
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    wc_d      = wc_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    if (state_q == IDLE && start) begin
      cols_d = cfg_cols;
      rows_d = cfg_rows;
      k3_d   = cfg_pool;
      relu_d = cfg_relu;
      col_d  = '0;
      row_d  = '0;
      hpos_d = '0;
      vpos_d = '0;
      wc_d   = '0;
    end

    if (s_hs) begin
      if (row_end) begin
        col_d  = '0;
        row_d  = row_q + ROW_W'(1);
        hpos_d = '0;
        wc_d   = '0;
        vpos_d = vdone ? 2'd0 : vpos_q + 2'd1;
      end else begin
        col_d  = col_q + COL_W'(1);
        hpos_d = hdone ? 2'd0 : hpos_q + 2'd1;
        wc_d   = hdone ? wc_q + IDX_W'(1) : wc_q;
      end
    end

    if (emit) begin
      m_valid_d = 1'b1;
      m_last_d  = last_win;
    end else if (m_hs) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (s_hs && last_px) state_d = FLUSH;
      FLUSH: begin
        if (!m_valid_q || m_ready) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // control registers: configuration, counters, output valid/last
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q    <= '0;
      rows_q    <= '0;
      k3_q      <= 1'b0;
      relu_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      wc_q      <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      cols_q    <= cols_d;
      rows_q    <= rows_d;
      k3_q      <= k3_d;
      relu_q    <= relu_d;
      col_q     <= col_d;
      row_q     <= row_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      wc_q      <= wc_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  // datapath registers: running max, row buffer, output data
  always_ff @(posedge clk) begin
    if (s_hs) hmax_q <= hcur;
    if (s_hs && hdone) rowbuf_q[wc_q] <= comb;
    if (emit) m_data_q <= relu(comb, relu_q);
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: a reference window-max model fills an
// expectation queue; a negedge monitor pops and compares each output.
module tb_maxpool_stream;

  localparam int DW = 16;
  localparam int MC = 256;
  localparam int RW = 16;
  localparam int CW = $clog2(MC + 1);

  logic          clk = 1'b0;
  logic          rst, start, cfg_pool, cfg_relu, s_valid, m_ready;
  logic [CW-1:0] cfg_cols;
  logic [RW-1:0] cfg_rows;
  logic [DW-1:0] s_data;
  logic          s_ready, m_valid, m_last, busy, done;
  logic [DW-1:0] m_data;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [DW:0] exp_q [$];
  logic signed [DW-1:0] pixv [0:255];

  logic          hold_prev = 1'b0;
  logic          done_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  maxpool_stream #(.DATA_WIDTH(DW), .MAX_COLS(MC), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .cfg_pool(cfg_pool), .cfg_relu(cfg_relu), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst) begin
      hold_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out got=%h last=%b required=none", m_data, m_last);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          assert ({m_last, m_data} === e) else begin
            bad++;
            $error("FAIL out got=%h last=%b required=%h last=%b", m_data, m_last, e[DW-1:0], e[DW]);
          end
        end
      end
      if (hold_prev && m_valid) begin
        total++;
        assert ({m_last, m_data} === {hold_last, hold_data}) else begin
          bad++;
          $error("FAIL hold got=%h/%b required=%h/%b", m_data, m_last, hold_data, hold_last);
        end
      end
      if (m_valid && !m_ready) begin
        total++;
        assert (s_ready === 1'b0) else begin
          bad++;
          $error("FAIL s_ready_blocked got=%b required=0", s_ready);
        end
      end
      if (done) begin
        total++;
        assert (done_prev === 1'b0) else begin
          bad++;
          $error("FAIL done_width got=two-cycle pulse required=one cycle");
        end
        done_cnt++;
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
      done_prev = done;
    end
  end

  task automatic feed_px(input logic [DW-1:0] v);
    bit hs = 0;
    s_valid = 1'b1;
    s_data  = v;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    total++;
    assert (hs) else begin
      bad++;
      $error("FAIL in_handshake got=timeout required=s_ready within 200 cycles");
    end
  endtask

  task automatic do_start(input int cols, input int rows, input bit k3, input bit relu);
    cfg_cols = CW'(cols);
    cfg_rows = RW'(rows);
    cfg_pool = k3;
    cfg_relu = relu;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode 0: pixel = index, 1: all -5, 2: random
  task automatic run_frame(input int cols, input int rows, input bit k3, input bit relu,
                           input int mode, input bit block, input bit poke);
    int k = k3 ? 3 : 2;
    int n = cols * rows;
    int d0;
    bit got;
    logic signed [DW-1:0] m;
    for (int i = 0; i < n; i++)
      pixv[i] = (mode == 0) ? DW'(i) : (mode == 1) ? -16'sd5 : DW'($urandom_range(0, 65535));
    for (int wr = 0; wr < rows / k; wr++)
      for (int wc = 0; wc < cols / k; wc++) begin
        m = pixv[wr * k * cols + wc * k];
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            if (pixv[(wr * k + r) * cols + wc * k + c] > m) m = pixv[(wr * k + r) * cols + wc * k + c];
        if (relu && m < 0) m = '0;
        exp_q.push_back({(wr == rows / k - 1) && (wc == cols / k - 1), m});
      end
    do_start(cols, rows, k3, relu);
    total++;
    assert (busy === 1'b1) else begin
      bad++;
      $error("FAIL busy_run got=%b required=1", busy);
    end
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if (poke && i == 6) begin
            // a start with different settings mid-frame must change nothing
            cfg_cols = CW'(2);
            cfg_rows = RW'(2);
            cfg_pool = ~k3;
            cfg_relu = ~relu;
            start    = 1'b1;
          end
          feed_px(pixv[i]);
          start = 1'b0;
        end
      end
      if (block) begin
        bit seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
          @(negedge clk);
          seen = m_valid;
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL done_seen got=timeout required=done pulse");
    end
    @(posedge clk);
    #1;
    total++;
    assert (busy === 1'b0) else begin
      bad++;
      $error("FAIL busy_idle got=%b required=0", busy);
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL outputs_missing got=%0d pending required=0", exp_q.size());
    end
    total++;
    assert (done_cnt - d0 == 1) else begin
      bad++;
      $error("FAIL done_count got=%0d required=1", done_cnt - d0);
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0; cfg_pool = 1'b0;
    cfg_relu = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    assert ({m_valid, m_last, done, busy, s_ready} === 5'b0) else begin
      bad++;
      $error("FAIL reset_outputs got=%b required=00000", {m_valid, m_last, done, busy, s_ready});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(4, 4, 1'b0, 1'b0, 0, 1'b0, 1'b1);  // 5, 7, 13, 15 ; mid-frame start ignored
    run_frame(5, 5, 1'b1, 1'b0, 0, 1'b0, 1'b0);  // single 12 with last
    run_frame(2, 2, 1'b0, 1'b0, 1, 1'b0, 1'b0);  // 0xFFFB
    run_frame(2, 2, 1'b0, 1'b1, 1, 1'b0, 1'b0);  // 0x0000
    run_frame(4, 4, 1'b0, 1'b0, 0, 1'b1, 1'b0);  // backpressure
    run_frame(1, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // no outputs
    run_frame(7, 6, 1'b0, 1'b0, 2, 1'b0, 1'b0);  // trailing column, signed random
    run_frame(7, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);  // K=3 relu random with stall

    // reset arriving with the 6th pixel of a 4x4 frame
    do_start(4, 4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) feed_px(DW'(i));
    s_valid = 1'b1;
    s_data  = DW'(5);
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    total++;
    assert ({m_valid, busy, s_ready} === 3'b0) else begin
      bad++;
      $error("FAIL midreset_state got=%b required=000", {m_valid, busy, s_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    run_frame(4, 4, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
